sram_mem_controller: RTL and testbench
======================================

// Module: sram_mem_controller
// PURPOSE
//   Sits directly downstream of the ARM core's MEM stage: turns one 32-bit data-memory read/write
//   into two 16-bit accesses on the external SRAM. It holds the pipeline (ready=0) until both
//   halves are done. Replaces the single-cycle data-memory array once the core is wired to SRAM.
// PARAMETERS
//   BASE_ADDR    1024  byte address that maps to SRAM half-word 0
//   SRAM_ADDR_W  18    SRAM address width, in half-words
//   WAIT_CYCLES  1     extra cycles each 16-bit access is held (legal range 1..15)
// PORTS
//   clk            in   1            clock; all state changes on the rising edge
//   rst            in   1            synchronous, active-low reset
//   wr_en          in   1            MEM-stage store request
//   rd_en          in   1            MEM-stage load request
//   address        in   32           byte address from the ALU result; bits [1:0] are ignored
//   write_data     in   32           store data (Val_Rm)
//   read_data      out  32           load result; registered
//   ready          out  1            0 = freeze the whole pipeline
//   sram_addr      out  SRAM_ADDR_W  SRAM half-word address
//   sram_dq_out    out  16           data driven to the SRAM
//   sram_dq_in     in   16           data returned by the SRAM
//   sram_dq_oe     out  1            1 = controller drives the DQ pins
//   sram_we_n      out  1            active-low write strobe
// BEHAVIOUR
//   Reset (rst==0 at an edge), including mid-operation:
//     - state=IDLE, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1
//     - any in-flight transfer is abandoned; half-written SRAM words are not repaired
//   States: IDLE -> LO -> HI -> DONE -> IDLE; wait counter wcnt is 4 bits.
//   IDLE:
//     - when wr_en|rd_en: latch op (wr_en has priority if both are set), latch the
//       word index (address-BASE_ADDR)>>2 and write_data; go to LO with wcnt=0
//   LO / HI:
//     - stay for WAIT_CYCLES+1 cycles; wcnt counts 0..WAIT_CYCLES, then advance
//   DONE: lasts exactly one cycle, then IDLE.
//   ready (combinational):
//     - 1 in DONE, and 1 in IDLE when wr_en|rd_en==0; 0 otherwise
//     - a request seen in IDLE drops ready in that same cycle
//   Latency: a request first seen in IDLE at cycle 0 reaches DONE at cycle 2*WAIT_CYCLES+3
//     (cycle 5 at the default).
//   sram_addr:
//     - registered: {idx,1'b0} in LO, {idx,1'b1} in HI, truncated to SRAM_ADDR_W
//     - addresses below BASE_ADDR wrap modulo 2^SRAM_ADDR_W; no error is flagged
//   Write:
//     - sram_dq_oe=1 in LO/HI; sram_dq_out = data[15:0] in LO, data[31:16] in HI
//     - sram_we_n=0 while wcnt<WAIT_CYCLES and 1 on the last cycle of each half,
//       giving two strobes with the address stable around each
//   Read:
//     - sram_dq_oe=0, sram_we_n=1
//     - sram_dq_in is captured into read_data[15:0] on the last LO cycle and into
//       read_data[31:16] on the last HI cycle
//     - read_data is held until the next read; writes never change it
//   Request changes during LO/HI/DONE are ignored, because the op is already latched.
//   A new request may start only from IDLE, so back-to-back transfers are separated by
//     DONE plus one IDLE cycle.
// STRUCTURE
//   Shared package sram_ctrl_pkg holds:
//     - state encoding (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3)
//     - the default BASE_ADDR and SRAM_ADDR_W constants
//   Sub-module sram_wait_counter (4-bit; load, enable, terminal-count output) drives
//     the LO/HI dwell.
//   Everything else is one FSM plus its datapath registers.
// TESTING
//   1 rst=0 for 2 edges during a read in HI -> next cycle IDLE, sram_we_n=1,
//     sram_dq_oe=0, read_data=0, ready=1.
//   2 wr_en, address=1024, write_data=32'hDEAD_BEEF, WAIT_CYCLES=1 ->
//     - SRAM model holds [0]=16'hBEEF and [1]=16'hDEAD
//     - ready=0 for cycles 0..4 and 1 in cycle 5
//     - exactly two sram_we_n low pulses
//   3 rd_en, address=1028 against model [2]=16'h5678, [3]=16'h1234 ->
//     read_data=32'h1234_5678 in DONE; it is held through a following write.
//   4 wr_en and rd_en both high at address=1032 -> a write is performed and read_data
//     is unchanged.
//   5 request deasserted in the cycle after acceptance -> the transfer still completes,
//     with the same DONE timing.
//   6 WAIT_CYCLES=3 with a read at address=1024+4*100 ->
//     - sram_addr=200 for 4 cycles, then 201 for 4 cycles
//     - ready returns to 1 at cycle 9

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the 32-bit-to-2x16-bit SRAM data-memory controller.
package sram_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_SRAM_ADDR_W = 18;
    localparam int unsigned DEF_WAIT_CYCLES = 1;
endpackage

// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response signals plus the external 16-bit SRAM pins.
interface sram_mem_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
);
    logic                   wr_en;
    logic                   rd_en;
    logic [31:0]            address;
    logic [31:0]            write_data;
    logic [31:0]            read_data;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [15:0]            sram_dq_out;
    logic [15:0]            sram_dq_in;
    logic                   sram_dq_oe;
    logic                   sram_we_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// 4-bit dwell counter: clears on load, counts on enable, flags when it reaches the limit.
module sram_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_limit,
    output logic [3:0] o_count,
    output logic       o_tc
);
    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_limit);
endmodule

// File: rtl/sram_mem_controller.sv
// Splits one 32-bit MEM-stage access into two 16-bit SRAM accesses, stalling the core meanwhile.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input logic                  clk,
    input logic                  rst,
    sram_mem_controller_if.slave bus
);
    localparam logic [3:0]  WAIT_L = 4'(WAIT_CYCLES);
    localparam int unsigned IDX_W  = SRAM_ADDR_W - 1;

    state_t                 r_state;
    logic                   r_is_wr;
    logic [IDX_W-1:0]       r_idx;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic [15:0]            r_dq_out;
    logic                   r_dq_oe;
    logic                   r_we_n;

    logic             w_req;
    logic             w_busy;
    logic             w_load;
    logic             w_en;
    logic             w_tc;
    logic             w_next_last;
    logic [3:0]       w_wcnt;
    logic [4:0]       w_wcnt_inc;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_bits;

    assign w_req      = bus.wr_en | bus.rd_en;
    assign w_busy     = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_load     = !w_busy || w_tc;
    assign w_en       = w_busy && !w_tc;
    // Below BASE_ADDR the subtraction wraps and the index is simply truncated.
    assign w_offset   = bus.address - 32'(BASE_ADDR);
    assign w_idx      = w_offset[SRAM_ADDR_W:2];
    assign w_wcnt_inc = {1'b0, w_wcnt} + 5'd1;
    assign w_next_last = (w_wcnt_inc == {1'b0, WAIT_L});
    assign w_unused_bits = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

    sram_wait_counter u_wait (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_en    (w_en),
        .i_limit (WAIT_L),
        .o_count (w_wcnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state     <= ST_LO;
                        r_is_wr     <= bus.wr_en;
                        r_idx       <= w_idx;
                        r_wdata     <= bus.write_data;
                        r_sram_addr <= {w_idx, 1'b0};
                        r_dq_out    <= bus.write_data[15:0];
                        r_dq_oe     <= bus.wr_en;
                        r_we_n      <= !bus.wr_en;
                    end
                end
                ST_LO: begin
                    if (w_tc) begin
                        r_state     <= ST_HI;
                        r_sram_addr <= {r_idx, 1'b1};
                        r_dq_out    <= r_wdata[31:16];
                        r_we_n      <= !r_is_wr;
                        if (!r_is_wr) r_rdata[15:0] <= bus.sram_dq_in;
                    end else begin
                        // Strobe lifts one cycle early so the address stays stable past it.
                        r_we_n <= !r_is_wr || w_next_last;
                    end
                end
                ST_HI: begin
                    if (w_tc) begin
                        r_state <= ST_DONE;
                        r_dq_oe <= 1'b0;
                        r_we_n  <= 1'b1;
                        if (!r_is_wr) r_rdata[31:16] <= bus.sram_dq_in;
                    end else begin
                        r_we_n <= !r_is_wr || w_next_last;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready       = (r_state == ST_DONE) || ((r_state == ST_IDLE) && !w_req);
    assign bus.read_data   = r_rdata;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_we_n   = r_we_n;
endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (WAIT_CYCLES 1 and 3) against behavioural SRAM models.
module tb_sram_mem_controller;
    localparam int AW = 18;
    localparam int W0 = 1;
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_mem_controller_if #(.SRAM_ADDR_W(AW)) b0 ();
    sram_mem_controller_if #(.SRAM_ADDR_W(AW)) b1 ();

    sram_mem_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    sram_mem_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W1)) u1 (
        .clk(clk), .rst(rst), .bus(b1));

    // SRAM models: asynchronous read, write while the strobe is low.
    logic [15:0] mem [2][256];
    logic        pre_en;
    int          pre_inst;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    assign b0.sram_dq_in = mem[0][b0.sram_addr[7:0]];
    assign b1.sram_dq_in = mem[1][b1.sram_addr[7:0]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_inst][pre_addr] <= pre_data;
        if (!b0.sram_we_n) mem[0][b0.sram_addr[7:0]] <= b0.sram_dq_out;
        if (!b1.sram_we_n) mem[1][b1.sram_addr[7:0]] <= b1.sram_dq_out;
    end

    logic          o_ready [2], o_oe [2], o_we_n [2], i_wr [2], i_rd [2];
    logic [AW-1:0] o_addr [2];
    logic [15:0]   o_dq [2];
    logic [31:0]   o_rd [2], i_addr [2], i_wd [2];

    assign o_ready[0] = b0.ready;       assign o_ready[1] = b1.ready;
    assign o_oe[0]    = b0.sram_dq_oe;  assign o_oe[1]    = b1.sram_dq_oe;
    assign o_we_n[0]  = b0.sram_we_n;   assign o_we_n[1]  = b1.sram_we_n;
    assign o_addr[0]  = b0.sram_addr;   assign o_addr[1]  = b1.sram_addr;
    assign o_dq[0]    = b0.sram_dq_out; assign o_dq[1]    = b1.sram_dq_out;
    assign o_rd[0]    = b0.read_data;   assign o_rd[1]    = b1.read_data;
    assign i_wr[0]    = b0.wr_en;       assign i_wr[1]    = b1.wr_en;
    assign i_rd[0]    = b0.rd_en;       assign i_rd[1]    = b1.rd_en;
    assign i_addr[0]  = b0.address;     assign i_addr[1]  = b1.address;
    assign i_wd[0]    = b0.write_data;  assign i_wd[1]    = b1.write_data;

    int checks = 0;
    int failures = 0;
    logic model_on = 1'b0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model: k = cycles since acceptance (0 = idle); a transfer spans 2*(W+1) cycles then one DONE cycle.
    int          k [2] = '{0, 0};
    int          wc [2] = '{W0, W1};
    logic        m_wr [2];
    logic [AW-2:0] m_idx [2];
    logic [31:0] m_wd [2];
    logic [31:0] m_rd [2];
    int          pulses [2] = '{0, 0};
    logic        prev_we [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int w, half, pos, last;
            logic [AW-1:0] ea;
            logic [31:0]   off;
            w    = wc[i];
            last = 2 * w + 3;
            half = (k[i] > 0) ? (k[i] - 1) / (w + 1) : 0;
            pos  = (k[i] > 0) ? (k[i] - 1) % (w + 1) : 0;
            ea   = {m_idx[i], half[0]};
            if (model_on) begin
                if (k[i] == 0) begin
                    chk("ready_idle", i, 32'(o_ready[i]), 32'(!(i_wr[i] | i_rd[i])));
                    chk("oe_idle", i, 32'(o_oe[i]), 32'd0);
                    chk("we_n_idle", i, 32'(o_we_n[i]), 32'd1);
                end else if (k[i] == last) begin
                    chk("ready_done", i, 32'(o_ready[i]), 32'd1);
                    chk("oe_done", i, 32'(o_oe[i]), 32'd0);
                    chk("we_n_done", i, 32'(o_we_n[i]), 32'd1);
                end else begin
                    chk("ready_busy", i, 32'(o_ready[i]), 32'd0);
                    chk("sram_addr", i, 32'(o_addr[i]), 32'(ea));
                    chk("oe_busy", i, 32'(o_oe[i]), 32'(m_wr[i]));
                    chk("we_n_busy", i, 32'(o_we_n[i]), 32'(!(m_wr[i] && pos < w)));
                    if (m_wr[i])
                        chk("dq_out", i, 32'(o_dq[i]), 32'(half[0] ? m_wd[i][31:16] : m_wd[i][15:0]));
                end
                chk("read_data", i, o_rd[i], m_rd[i]);
            end
            if (prev_we[i] && !o_we_n[i]) pulses[i]++;
            prev_we[i] = o_we_n[i];
            if (!rst) begin
                k[i]    = 0;
                m_rd[i] = '0;
            end else if (k[i] == 0) begin
                if (i_wr[i] | i_rd[i]) begin
                    k[i]     = 1;
                    m_wr[i]  = i_wr[i];
                    off      = i_addr[i] - 32'd1024;
                    m_idx[i] = off[AW:2];
                    m_wd[i]  = i_wd[i];
                end
            end else begin
                if (k[i] != last && !m_wr[i] && pos == w) begin
                    if (half == 0) m_rd[i][15:0]  = mem[i][ea[7:0]];
                    else           m_rd[i][31:16] = mem[i][ea[7:0]];
                end
                k[i] = (k[i] == last) ? 0 : k[i] + 1;
            end
        end
    end

    logic [AW-1:0] addr_log [16];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int inst, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        if (inst == 0) begin
            b0.wr_en = wr; b0.rd_en = rd; b0.address = a; b0.write_data = d;
        end else begin
            b1.wr_en = wr; b1.rd_en = rd; b1.address = a; b1.write_data = d;
        end
    endtask

    task automatic preload(input int inst, input logic [7:0] a, input logic [15:0] d);
        pre_inst = inst; pre_addr = a; pre_data = d; pre_en = 1'b1;
        tick(1);
        pre_en = 1'b0;
    endtask

    // Issues one request; returns the cycle ready comes back (-1 on timeout) and read_data there.
    task automatic xfer(input int inst, input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, output int done_c,
                        output logic [31:0] rd_done);
        logic r;
        done_c  = -1;
        rd_done = '0;
        drive(inst, wr, rd, a, d);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            r = (inst == 0) ? b0.ready : b1.ready;
            if (c < 16) addr_log[c] = (inst == 0) ? b0.sram_addr : b1.sram_addr;
            if (c == 0) chk("ready_c0", inst, 32'(r), 32'd0);
            if (c > 0 && r) begin
                done_c  = c;
                rd_done = (inst == 0) ? b0.read_data : b1.read_data;
                break;
            end
            tick(1);
            if (!hold) drive(inst, 1'b0, 1'b0, a, d);
        end
        tick(1);
        drive(inst, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int          dc;
        int          p0;
        logic [31:0] rdv;
        rst = 1'b0;
        pre_en = 1'b0; pre_inst = 0; pre_addr = '0; pre_data = '0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(2);
        rst = 1'b1;
        model_on = 1'b1;
        tick(1);
        preload(0, 8'd2, 16'h5678);
        preload(0, 8'd3, 16'h1234);
        preload(1, 8'd200, 16'h9ABC);
        preload(1, 8'd201, 16'h5678);

        // Reset held for two edges while a read is in its high half.
        drive(0, 1'b0, 1'b1, 32'd1028, 32'd0);
        tick(3);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 0, 32'(b0.ready), 32'd1);
        chk("rst_we_n", 0, 32'(b0.sram_we_n), 32'd1);
        chk("rst_oe", 0, 32'(b0.sram_dq_oe), 32'd0);
        chk("rst_read_data", 0, b0.read_data, 32'd0);
        tick(1);

        p0 = pulses[0];
        xfer(0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b1, dc, rdv);
        chk("wr_latency", 0, 32'(dc), 32'd5);
        chk("wr_mem0", 0, 32'(mem[0][0]), 32'h0000_BEEF);
        chk("wr_mem1", 0, 32'(mem[0][1]), 32'h0000_DEAD);
        chk("wr_pulses", 0, 32'(pulses[0] - p0), 32'd2);

        xfer(0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b1, dc, rdv);
        chk("rd_latency", 0, 32'(dc), 32'd5);
        chk("rd_data_done", 0, rdv, 32'h1234_5678);
        xfer(0, 1'b1, 1'b0, 32'd1036, 32'hCAFE_F00D, 1'b1, dc, rdv);
        @(negedge clk);
        chk("rd_held_after_wr", 0, b0.read_data, 32'h1234_5678);
        chk("wr2_mem6", 0, 32'(mem[0][6]), 32'h0000_F00D);
        tick(1);

        xfer(0, 1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 1'b1, dc, rdv);
        chk("both_latency", 0, 32'(dc), 32'd5);
        chk("both_mem4", 0, 32'(mem[0][4]), 32'h0000_F00D);
        chk("both_mem5", 0, 32'(mem[0][5]), 32'h0000_0BAD);
        chk("both_read_data", 0, rdv, 32'h1234_5678);

        xfer(0, 1'b1, 1'b0, 32'd1040, 32'h1111_2222, 1'b0, dc, rdv);
        chk("drop_latency", 0, 32'(dc), 32'd5);
        chk("drop_mem8", 0, 32'(mem[0][8]), 32'h0000_2222);
        chk("drop_mem9", 0, 32'(mem[0][9]), 32'h0000_1111);

        xfer(0, 1'b0, 1'b1, 32'd1030, 32'd0, 1'b0, dc, rdv);
        chk("lowbits_read", 0, rdv, 32'h1234_5678);

        xfer(0, 1'b1, 1'b0, 32'd1020, 32'h7777_8888, 1'b1, dc, rdv);
        chk("wrap_addr_lo", 0, 32'(addr_log[1]), 32'h0003_FFFE);
        chk("wrap_addr_hi", 0, 32'(addr_log[3]), 32'h0003_FFFF);
        chk("wrap_mem", 0, 32'(mem[0][254]), 32'h0000_8888);

        xfer(1, 1'b0, 1'b1, 32'd1424, 32'd0, 1'b1, dc, rdv);
        chk("w3_latency", 1, 32'(dc), 32'd9);
        chk("w3_addr_c1", 1, 32'(addr_log[1]), 32'd200);
        chk("w3_addr_c4", 1, 32'(addr_log[4]), 32'd200);
        chk("w3_addr_c5", 1, 32'(addr_log[5]), 32'd201);
        chk("w3_addr_c8", 1, 32'(addr_log[8]), 32'd201);
        chk("w3_read_data", 1, rdv, 32'h5678_9ABC);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
